// File: rtl/ram_frame_tx.sv
// Frame serializer: streams len bytes from the frame RAM onto o_tx, MSB-first, no gaps.
// Define MANCHESTER_EN for IEEE 802.3 Manchester line coding; NRZ otherwise.
module ram_frame_tx #(
  parameter int ADDR_WIDTH   = 7,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH:0]   i_len,
  output logic [ADDR_WIDTH-1:0] o_r_addr,
  input  logic [7:0]            i_r_byte,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]       LAST_CLK = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]       HALF_CLK = CW'(CLKS_PER_BIT / 2);
  localparam logic [ADDR_WIDTH:0] MAX_LEN  = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, SHIFT} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [ADDR_WIDTH:0]   len_reg, len_next;
  logic [ADDR_WIDTH:0]   byte_cnt_reg, byte_cnt_next;
  logic [2:0]            bit_cnt_reg, bit_cnt_next;
  logic [CW-1:0]         clk_cnt_reg, clk_cnt_next;
  logic [7:0]            shift_reg, shift_next;
  logic                  tx_reg, tx_next;
  logic                  busy_reg, busy_next;
  logic                  done_reg, done_next;
  logic                  line_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      len_reg      <= '0;
      byte_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      clk_cnt_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      len_reg      <= len_next;
      byte_cnt_reg <= byte_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      clk_cnt_reg  <= clk_cnt_next;
      shift_reg    <= shift_next;
      tx_reg       <= tx_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    len_next      = len_reg;
    byte_cnt_next = byte_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    clk_cnt_next  = clk_cnt_reg;
    shift_next    = shift_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    tx_next       = 1'b0;
    line_bit      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (i_start) begin
          if (i_len == '0) begin
            done_next = 1'b1;
          end else begin
            len_next   = (i_len > MAX_LEN) ? MAX_LEN : i_len;
            addr_next  = '0;
            busy_next  = 1'b1;
            state_next = FETCH;
          end
        end
      end
      FETCH: state_next = LOAD;
      LOAD: begin
        shift_next    = i_r_byte;
        addr_next     = addr_reg + 1'b1;
        byte_cnt_next = {{ADDR_WIDTH{1'b0}}, 1'b1};
        bit_cnt_next  = '0;
        clk_cnt_next  = '0;
        state_next    = SHIFT;
      end
      SHIFT: begin
        if (clk_cnt_reg == LAST_CLK) begin
          clk_cnt_next = '0;
          if (bit_cnt_reg == 3'd7) begin
            bit_cnt_next = '0;
            // Next byte was addressed a whole byte time ago, so i_r_byte is settled.
            if (byte_cnt_reg < len_reg) begin
              shift_next    = i_r_byte;
              addr_next     = addr_reg + 1'b1;
              byte_cnt_next = byte_cnt_reg + 1'b1;
            end else begin
              shift_next = '0;
              busy_next  = 1'b0;
              done_next  = 1'b1;
              state_next = IDLE;
            end
          end else begin
            shift_next   = {shift_reg[6:0], 1'b0};
            bit_cnt_next = bit_cnt_reg + 3'd1;
          end
        end else begin
          clk_cnt_next = clk_cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Line level is registered from the next-state values so o_tx is glitch-free.
`ifdef MANCHESTER_EN
    line_bit = shift_next[7] ^ (clk_cnt_next < HALF_CLK);
`else
    line_bit = shift_next[7];
`endif
    if (state_next == SHIFT)
      tx_next = line_bit;
  end

  assign o_r_addr = addr_reg;
  assign o_tx     = tx_reg;
  assign o_busy   = busy_reg;
  assign o_done   = done_reg;

endmodule

// File: tb/tb_ram_frame_tx.sv
// Directed bench for ram_frame_tx with a registered-read RAM model and CLKS_PER_BIT=4.
// Expected line levels follow MANCHESTER_EN the same way as the design build.
module tb_ram_frame_tx;
  localparam int AW = 7;
  localparam int C  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [AW:0]   i_len = '0;
  logic [AW-1:0] o_r_addr;
  logic [7:0]    i_r_byte;
  logic          o_tx, o_busy, o_done;
  logic [7:0]    mem [128];
  int            errors = 0;
  int            checks = 0;

  ram_frame_tx #(.ADDR_WIDTH(AW), .CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_len(i_len),
    .o_r_addr(o_r_addr), .i_r_byte(i_r_byte),
    .o_tx(o_tx), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) i_r_byte <= mem[o_r_addr];

  // Start a frame and compare every cycle from E0 to one cycle past o_done.
  task automatic run_frame(input string name, input int len_req, input bit poke);
    int n, total, c, b, bi, p;
    int bad_tx, bad_busy, bad_done, bad_addr;
    string m_tx, m_busy, m_done, m_addr;
    logic exp_tx, exp_busy, exp_done, bitv;
    logic [AW-1:0] exp_addr;
    bad_tx = 0; bad_busy = 0; bad_done = 0; bad_addr = 0;
    n = (len_req > 128) ? 128 : len_req;
    total = 2 + 8 * n * C;
    @(posedge clk); #1 i_start = 1'b1; i_len = len_req[AW:0];
    @(posedge clk); #1 i_start = 1'b0;
    for (int t = 0; t <= total + 1; t++) begin
      @(negedge clk);
      exp_tx = 1'b0;
      if (t >= 2 && t < total) begin
        c = t - 2; b = c / (8 * C); bi = (c / C) % 8; p = c % C;
        bitv = mem[b][7 - bi];
`ifdef MANCHESTER_EN
        exp_tx = (p < C / 2) ? ~bitv : bitv;
`else
        exp_tx = bitv;
`endif
      end
      exp_busy = (t < total);
      exp_done = (t == total);
      if (t < 2)            exp_addr = '0;
      else if (t >= total)  exp_addr = AW'(n % 128);
      else                  exp_addr = AW'(((t - 2) / (8 * C) + 1) % 128);
      if (o_tx !== exp_tx) begin
        if (bad_tx == 0) m_tx = $sformatf("t=%0d got=%b want=%b", t, o_tx, exp_tx);
        bad_tx++;
      end
      if (o_busy !== exp_busy) begin
        if (bad_busy == 0) m_busy = $sformatf("t=%0d got=%b want=%b", t, o_busy, exp_busy);
        bad_busy++;
      end
      if (o_done !== exp_done) begin
        if (bad_done == 0) m_done = $sformatf("t=%0d got=%b want=%b", t, o_done, exp_done);
        bad_done++;
      end
      if (o_r_addr !== exp_addr) begin
        if (bad_addr == 0) m_addr = $sformatf("t=%0d got=%0d want=%0d", t, o_r_addr, exp_addr);
        bad_addr++;
      end
      if (poke && t == 40) begin i_start = 1'b1; i_len = 5; end
      if (poke && t == 41) i_start = 1'b0;
    end
    checks += 4;
    if (bad_tx != 0)   begin errors++; $display("FAIL %s tx: %0d bad cycles, first %s", name, bad_tx, m_tx); end
    if (bad_busy != 0) begin errors++; $display("FAIL %s busy: %0d bad cycles, first %s", name, bad_busy, m_busy); end
    if (bad_done != 0) begin errors++; $display("FAIL %s done: %0d bad cycles, first %s", name, bad_done, m_done); end
    if (bad_addr != 0) begin errors++; $display("FAIL %s addr: %0d bad cycles, first %s", name, bad_addr, m_addr); end
    $display("frame %s len=%0d bytes=%0d cycles=%0d", name, len_req, n, total);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks += 4;
    if (o_tx !== 1'b0)     begin errors++; $display("FAIL reset_tx got=%b want=0", o_tx); end
    if (o_busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got=%b want=0", o_busy); end
    if (o_done !== 1'b0)   begin errors++; $display("FAIL reset_done got=%b want=0", o_done); end
    if (o_r_addr !== '0)   begin errors++; $display("FAIL reset_addr got=%0d want=0", o_r_addr); end
    rst_n = 1'b1;
    $display("reset released");
  endtask

  task automatic test_zero_len();
    @(posedge clk); #1 i_start = 1'b1; i_len = '0;
    @(posedge clk); #1 i_start = 1'b0;
    @(negedge clk);
    checks += 3;
    if (o_done !== 1'b1)  begin errors++; $display("FAIL zero_done got=%b want=1", o_done); end
    if (o_busy !== 1'b0)  begin errors++; $display("FAIL zero_busy got=%b want=0", o_busy); end
    if (o_r_addr !== '0)  begin errors++; $display("FAIL zero_addr got=%0d want=0", o_r_addr); end
    @(negedge clk);
    checks += 2;
    if (o_done !== 1'b0)  begin errors++; $display("FAIL zero_done_pulse got=%b want=0", o_done); end
    if (o_busy !== 1'b0)  begin errors++; $display("FAIL zero_busy_after got=%b want=0", o_busy); end
    $display("zero-length request retired");
  endtask

  task automatic test_single_a5();
    mem[0] = 8'hA5;
    run_frame("single_a5", 1, 1'b0);
  endtask

  task automatic test_three_bytes();
    mem[0] = 8'hFF; mem[1] = 8'h00; mem[2] = 8'h81;
    run_frame("three_bytes", 3, 1'b0);
  endtask

  task automatic test_start_mid_frame();
    mem[0] = 8'h3C; mem[1] = 8'hC3;
    run_frame("start_mid_frame", 2, 1'b1);
  endtask

  task automatic test_len_clamp();
    for (int i = 0; i < 128; i++) mem[i] = 8'(i * 37 + 11);
    run_frame("len_clamp", 200, 1'b0);
  endtask

  task automatic test_back_to_back();
    mem[0] = 8'h96; mem[1] = 8'h5A;
    run_frame("b2b_first", 2, 1'b0);
    mem[0] = 8'h0F;
    run_frame("b2b_second", 1, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    mem[0] = 8'hF0; mem[1] = 8'hFF;
    @(posedge clk); #1 i_start = 1'b1; i_len = 2;
    @(posedge clk); #1 i_start = 1'b0;
    // Bit 3 of the second byte, second half of the bit period (line high in both codings).
    for (int t = 0; t <= 48; t++) @(negedge clk);
    checks += 1;
    if (o_tx !== 1'b1) begin errors++; $display("FAIL rst_pre_tx got=%b want=1", o_tx); end
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (o_tx !== 1'b0)    begin errors++; $display("FAIL rst_async_tx got=%b want=0", o_tx); end
    if (o_busy !== 1'b0)  begin errors++; $display("FAIL rst_async_busy got=%b want=0", o_busy); end
    if (o_r_addr !== '0)  begin errors++; $display("FAIL rst_async_addr got=%0d want=0", o_r_addr); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks += 1;
      if (o_done !== 1'b0) begin errors++; $display("FAIL rst_no_done cycle=%0d got=%b want=0", k, o_done); end
    end
    rst_n = 1'b1;
    $display("reset mid-frame applied and released");
    mem[0] = 8'h6B;
    run_frame("after_reset", 1, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    test_reset();
    test_zero_len();
    test_single_a5();
    test_three_bytes();
    test_start_mid_frame();
    test_len_clamp();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
